md_unit: RTL



---
 rtl/md_unit.sv | 99 +++++++++
 1 files changed

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with architectural HI/LO registers
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   data1, data2   operands A/B; data1 is also the MTHI/MTLO source
//   start, op      request and opcode (0 MULT 1 MULTU 2 DIV 3 DIVU 4 MTHI 5 MTLO 6 MADD 7 MSUB)
//   cancel         flush: aborts an in-flight op, suppresses a same-cycle start
//   busy           operation in progress
//   hi, lo         HI/LO registers
// Optional MADD/MSUB accumulate (ops 6/7) is enabled by defining MD_MADD_EN.
module md_unit #(
  parameter int WIDTH = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             cancel,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic {IDLE, RUN} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [2:0] op_q, op_d;
  logic accept, launch, done, is_md, is_div, sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, q_mag, r_mag, quo, rem;
  logic [2*WIDTH-1:0] ax, bx, prod, mres, res;
`ifdef MD_MADD_EN
  assign is_md = (op <= 3'd3) || (op >= 3'd6);
`else
  assign is_md = op <= 3'd3;
`endif
  assign accept = (state_q == IDLE) && start && !cancel;
  assign launch = accept && is_md;
  // The counter holds the remaining busy cycles; the last one commits the result.
  assign done = (state_q == RUN) && !cancel && (cnt_q == CW'(1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb state_d = (state_q == IDLE) ? (launch ? RUN : IDLE) : ((cancel || done) ? IDLE : RUN);
  always_comb begin
    busy = state_q == RUN;
    hi = hi_q;
    lo = lo_q;
  end
  always_comb begin
    is_div = (op_q == 3'd2) || (op_q == 3'd3);
    sgn = (op_q != 3'd1) && (op_q != 3'd3);
    ax = {{WIDTH{sgn & a_q[WIDTH-1]}}, a_q};
    bx = {{WIDTH{sgn & b_q[WIDTH-1]}}, b_q};
    prod = ax * bx;
    // Signed divide runs on magnitudes; quotient sign is the XOR, remainder follows the dividend.
    a_neg = sgn & a_q[WIDTH-1];
    b_neg = sgn & b_q[WIDTH-1];
    a_mag = a_neg ? -a_q : a_q;
    b_mag = b_neg ? -b_q : b_q;
    q_mag = a_mag / b_mag;
    r_mag = a_mag % b_mag;
    quo = (b_q == '0) ? '1 : ((a_neg ^ b_neg) ? -q_mag : q_mag);
    rem = (b_q == '0) ? a_q : (a_neg ? -r_mag : r_mag);
`ifdef MD_MADD_EN
    mres = (op_q == 3'd6) ? {hi_q, lo_q} + prod : (op_q == 3'd7) ? {hi_q, lo_q} - prod : prod;
`else
    mres = prod;
`endif
    res = is_div ? {rem, quo} : mres;
    cnt_d = launch ? ((op[1] && !op[2]) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES))
          : ((state_q == RUN) && !cancel) ? cnt_q - CW'(1) : '0;
    a_d = launch ? data1 : a_q;
    b_d = launch ? data2 : b_q;
    op_d = launch ? op : op_q;
    hi_d = done ? res[2*WIDTH-1:WIDTH] : (accept && op == 3'd4) ? data1 : hi_q;
    lo_d = done ? res[WIDTH-1:0] : (accept && op == 3'd5) ? data1 : lo_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
endmodule
